// File: rtl/combat_resolver.sv
// Applies a settled shot (damage/range) to the opponent's HP, alternates turns
// between two players and decides KO, timeout win or timeout draw.
module combat_resolver #(
  parameter int unsigned MAX_HP     = 100,
  parameter int unsigned MAX_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic [5:0] damage,
  input  logic [4:0] range,
  input  logic [4:0] distance,
  input  logic       new_game,
  output logic [7:0] hp0,
  output logic [7:0] hp1,
  output logic       turn,
  output logic       hit,
  output logic       busy,
  output logic [7:0] round,
  output logic       game_over,
  output logic       winner,
  output logic       draw
);

  localparam int unsigned HP_W  = 8;
  localparam int unsigned DMG_W = 6;
  localparam int unsigned RNG_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_APPLY,
    S_CHECK,
    S_GAME_OVER
  } state_t;

  state_t state;

  logic [DMG_W-1:0] damage_q;
  logic [RNG_W-1:0] range_q;
  logic [RNG_W-1:0] distance_q;

  logic [HP_W-1:0] eff_c;
  logic [HP_W-1:0] opp_hp_c;
  logic [HP_W-1:0] opp_left_c;
  logic [HP_W-1:0] next_round_c;
  logic            restart_c;

  // Shot resolution against the player who is not on turn
  always_comb begin
    eff_c        = '0;
    opp_hp_c     = '0;
    opp_left_c   = '0;
    next_round_c = '0;
    restart_c    = 1'b0;
    if (distance_q <= range_q) begin
      eff_c = HP_W'(damage_q);
    end
    opp_hp_c = turn ? hp0 : hp1;
    if (opp_hp_c > eff_c) begin
      opp_left_c = opp_hp_c - eff_c;
    end
    next_round_c = round + HP_W'(turn);
    restart_c    = (state == S_GAME_OVER) && new_game;
  end

  // A new game from GAME_OVER restores exactly the reset image
  always_ff @(posedge clk) begin
    if (!rst || restart_c) begin
      state      <= S_IDLE;
      hp0        <= HP_W'(MAX_HP);
      hp1        <= HP_W'(MAX_HP);
      turn       <= 1'b0;
      hit        <= 1'b0;
      busy       <= 1'b0;
      round      <= '0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      draw       <= 1'b0;
      damage_q   <= '0;
      range_q    <= '0;
      distance_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            state <= S_CAPTURE;
            busy  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          damage_q   <= damage;
          range_q    <= range;
          distance_q <= distance;
          state      <= S_APPLY;
        end
        S_APPLY: begin
          if (turn) begin
            hp0 <= opp_left_c;
          end else begin
            hp1 <= opp_left_c;
          end
          hit   <= (eff_c != '0);
          state <= S_CHECK;
        end
        S_CHECK: begin
          busy <= 1'b0;
          if (opp_hp_c == '0) begin
            game_over <= 1'b1;
            winner    <= turn;
            draw      <= 1'b0;
            state     <= S_GAME_OVER;
          end else begin
            turn  <= ~turn;
            round <= next_round_c;
            // round only advances after P1, so equality is only reachable then
            if (next_round_c == HP_W'(MAX_ROUNDS)) begin
              game_over <= 1'b1;
              state     <= S_GAME_OVER;
              if (hp0 > hp1) begin
                winner <= 1'b0;
              end else if (hp1 > hp0) begin
                winner <= 1'b1;
              end else begin
                winner <= 1'b0;
                draw   <= 1'b1;
              end
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAME_OVER: begin
          state <= S_GAME_OVER;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
- Downstream consumer of the per-shot attack stage: takes the shot outputs (damage, range), applies them to the opposing player's hit points and alternates turns between two players.
- Tracks HP, round count and game-over/winner/draw status for the display and top-level game FSM.
- Driven by the same `fire` strobe that clocks the attack stage's update.
- Captures that stage's outputs one cycle after the strobe, once they have settled.

Parameters:
- MAX_HP, 100, starting HP per player (1..255).
- MAX_ROUNDS, 10, full rounds (P0 shot + P1 shot) before a timeout decision (1..255).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-low reset
- fire  input  1  one-cycle shot strobe from the current player (same event as the attack stage's update)
- damage  input  6  shot damage from the attack stage, unsigned
- range  input  5  weapon range from the attack stage, unsigned
- distance  input  5  current distance between players, unsigned
- new_game  input  1  one-cycle strobe, restarts the game from GAME_OVER
- hp0  output  8  player 0 HP
- hp1  output  8  player 1 HP
- turn  output  1  player whose shot is next (0/1)
- hit  output  1  last resolved shot landed nonzero damage
- busy  output  1  high in any state except IDLE and GAME_OVER
- round  output  8  completed full rounds
- game_over  output  1  game finished
- winner  output  1  winning player, valid when game_over=1 and draw=0
- draw  output  1  game ended level on timeout

Behaviour:
- Reset (rst=0 at a rising edge, any state):
  - hp0=hp1=MAX_HP; turn=0; hit=0; round=0.
  - game_over=0; winner=0; draw=0; state=IDLE.
  - All in-flight work is discarded, including mid-CAPTURE/APPLY/CHECK; no partial HP update survives.
- States: IDLE, CAPTURE, APPLY, CHECK, GAME_OVER.
- IDLE:
  - fire=1 -> CAPTURE.
  - new_game is ignored.
- CAPTURE: register damage, range, distance into internal copies -> APPLY.
- APPLY:
  - eff = (distance_q <= range_q) ? damage_q : 0.
  - The opponent (the player not equal to turn) loses eff HP, saturating at 0: hp = (hp > eff) ? hp - eff : 0.
  - hit <= (eff != 0).
  - All comparisons are unsigned; damage is zero-extended to 8 bits.
  - -> CHECK.
- CHECK, evaluated in priority order:
  1. Opponent HP == 0:
     - game_over <= 1, winner <= turn, draw <= 0 -> GAME_OVER.
     - turn and round are not changed.
  2. Otherwise turn <= ~turn.
     - If turn was 1, round <= round + 1.
     - If that new round equals MAX_ROUNDS:
       - game_over <= 1.
       - hp0 > hp1: winner <= 0.
       - hp1 > hp0: winner <= 1.
       - hp0 == hp1: draw <= 1, winner <= 0.
       - -> GAME_OVER.
     - Else -> IDLE.
- GAME_OVER:
  - fire is ignored.
  - new_game=1 restores all reset values (including game_over=0) -> IDLE.
- Latency: fire at edge t.
  - CAPTURE at t+1.
  - HP and hit updated at edge t+2.
  - turn/round/game_over updated at edge t+3.
  - busy high from edge t+1 through t+3 inclusive.
- fire while busy=1 is ignored and not queued.
  - fire on the same edge CHECK returns to IDLE is also ignored; fire is only accepted in IDLE.
- Dry fire (damage=0, e.g. empty magazine) is not special-cased: eff=0, hit=0, turn still passes, round still counts.
- round never exceeds MAX_ROUNDS. hit holds its value until the next APPLY.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset: drive rst=0 for 2 cycles then release -> hp0=hp1=100, turn=0, round=0, busy=0, game_over=0, hit=0.
- In-range hit:
  - Stimulus: turn=0, fire with damage=42, range=3, distance=2.
  - Required: hp1=58, hit=1 three edges after fire; turn=1, round=0 at the fourth edge; hp0 unchanged.
- Out-of-range miss:
  - Stimulus: damage=50, range=2, distance=3.
  - Required: HP unchanged, hit=0, turn toggles.
  - A second shot by P1 then gives round=1.
- Saturating KO:
  - Stimulus: preload hp1 to 10 via prior shots, then P0 fires damage=42 in range.
  - Required: hp1=0, game_over=1, winner=0, draw=0, turn stays 0.
  - A subsequent fire is ignored; new_game restores hp0=hp1=100, round=0.
- Busy/reset:
  - Stimulus 1: a second fire one cycle after the first.
  - Required: no second HP change.
  - Stimulus 2: rst=0 asserted while in APPLY.
  - Required: hp values back to 100, state IDLE, no damage applied.
- Timeout draw:
  - Stimulus: MAX_ROUNDS=2, all four shots at distance > range.
  - Required: after P1's second shot, round=2, game_over=1, draw=1, winner=0.
